// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial front end and its downstream detectors.
package serial_pkg;

    // Default word width for serializer instances and detector benches.
    localparam int unsigned SER_W = 8;

    // Serializer FSM state encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

endpackage : serial_pkg

// File: rtl/ser_hold_reg.sv
// Single-entry holding register: parks the next word while the current one shifts out.
module ser_hold_reg
    import serial_pkg::*;
#(
    parameter int unsigned W = SER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] din,
    output logic [W-1:0] hold,
    output logic         hold_full,
    output logic         s_ready
);

    // Capture a word on load, release the slot on drain (never both in one cycle).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (load) begin
            hold      <= din;
            hold_full <= 1'b1;
        end else if (drain) begin
            hold_full <= 1'b0;
        end
    end

    // Ready depends only on registered state, so there is no path from s_valid.
    always_comb begin
        s_ready = !hold_full;
    end

endmodule : ser_hold_reg

// File: rtl/word_serializer.sv
// Parallel-to-serial converter: one bit per en strobe, with a one-word hold for gapless streaming.
module word_serializer
    import serial_pkg::*;
#(
    parameter int unsigned W          = SER_W,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] s_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         en,
    output logic         dout,
    output logic         dout_valid,
    output logic         word_done,
    output logic         busy
);

    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    ser_state_t      state;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   bitcnt;
    logic [W-1:0]    hold;
    logic            hold_full;
    logic            xfer;
    logic            last_bit;
    logic            hold_load;
    logic            hold_drain;
    logic            out_bit;
    logic [W-1:0]    shifted;

    // Handshake, terminal-count and bit-selection decode.
    always_comb begin
        xfer       = s_valid && s_ready;
        last_bit   = (state == ST_SHIFT) && en && (bitcnt == LAST);
        // On the last bit with an empty hold, an incoming word goes straight into shreg.
        hold_load  = xfer && (state == ST_SHIFT) && !last_bit;
        hold_drain = last_bit && hold_full;
        if (MSB_FIRST) begin
            out_bit = shreg[W-1];
            shifted = {shreg[W-2:0], 1'b0};
        end else begin
            out_bit = shreg[0];
            shifted = {1'b0, shreg[W-1:1]};
        end
        busy = (state == ST_SHIFT);
    end

    ser_hold_reg #(
        .W (W)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (hold_load),
        .drain     (hold_drain),
        .din       (s_data),
        .hold      (hold),
        .hold_full (hold_full),
        .s_ready   (s_ready)
    );

    // FSM, shift register, bit counter and registered serial outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    dout       <= IDLE_LEVEL;
                    dout_valid <= 1'b0;
                    word_done  <= 1'b0;
                    if (xfer) begin
                        shreg  <= s_data;
                        bitcnt <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (en) begin
                        dout       <= out_bit;
                        dout_valid <= 1'b1;
                        if (bitcnt == LAST) begin
                            word_done <= 1'b1;
                            bitcnt    <= '0;
                            if (hold_full) begin
                                shreg <= hold;
                            end else if (xfer) begin
                                shreg <= s_data;
                            end else begin
                                shreg <= shifted;
                                state <= ST_IDLE;
                            end
                        end else begin
                            word_done <= 1'b0;
                            shreg     <= shifted;
                            bitcnt    <= bitcnt + 1'b1;
                        end
                    end else begin
                        dout       <= IDLE_LEVEL;
                        dout_valid <= 1'b0;
                        word_done  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : word_serializer

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: MSB-first default instance plus an LSB-first instance.
module tb_word_serializer;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       dout;
    logic       dout_valid;
    logic       word_done;
    logic       busy;
    logic [7:0] s_data2;
    logic       s_valid2;
    logic       s_ready2;
    logic       dout2;
    logic       dout_valid2;
    logic       word_done2;
    logic       busy2;

    int total;
    int bad;

    word_serializer #(
        .W          (8),
        .MSB_FIRST  (1'b1),
        .IDLE_LEVEL (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .en         (en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    word_serializer #(
        .W          (8),
        .MSB_FIRST  (1'b0),
        .IDLE_LEVEL (1'b0)
    ) dut_lsb (
        .clk        (clk),
        .reset      (reset),
        .s_data     (s_data2),
        .s_valid    (s_valid2),
        .s_ready    (s_ready2),
        .en         (en),
        .dout       (dout2),
        .dout_valid (dout_valid2),
        .word_done  (word_done2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task test_reset;
        reset    = 1'b1;
        en       = 1'b0;
        s_data   = 8'h00;
        s_valid  = 1'b0;
        s_data2  = 8'h00;
        s_valid2 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({dout, dout_valid, word_done, s_ready, busy} !== 5'b00010) begin
            bad++;
            $display("FAIL reset_state got=%b want=00010", {dout, dout_valid, word_done, s_ready, busy});
        end
        total++;
        if ({dout2, dout_valid2, word_done2, s_ready2, busy2} !== 5'b00010) begin
            bad++;
            $display("FAIL reset_state_lsb got=%b want=00010", {dout2, dout_valid2, word_done2, s_ready2, busy2});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task test_single;
        logic [7:0] w;
        w = 8'hB0;
        s_data = w; s_valid = 1'b1; en = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        total++;
        if ({busy, dout_valid} !== 2'b10) begin
            bad++;
            $display("FAIL single_load got=%b want=10", {busy, dout_valid});
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if ({dout_valid, dout, word_done} !== {1'b1, w[7-i], (i == 7)}) begin
                bad++;
                $display("FAIL single_bit%0d got=%b want=%b", i, {dout_valid, dout, word_done}, {1'b1, w[7-i], (i == 7)});
            end
        end
        total++;
        if ({busy, s_ready} !== 2'b01) begin
            bad++;
            $display("FAIL single_end got=%b want=01", {busy, s_ready});
        end
        @(negedge clk);
        total++;
        if ({dout, dout_valid, word_done} !== 3'b000) begin
            bad++;
            $display("FAIL single_idle got=%b want=000", {dout, dout_valid, word_done});
        end
        en = 1'b0;
    endtask

    task test_back_to_back;
        logic [15:0] st;
        st = 16'hB05A;
        s_data = 8'hB0; s_valid = 1'b1; en = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_empty got=%b want=1", s_ready);
        end
        s_data = 8'h5A;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) s_valid = 1'b0;
            total++;
            if ({dout_valid, dout, word_done} !== {1'b1, st[15-i], (i == 7 || i == 15)}) begin
                bad++;
                $display("FAIL b2b_bit%0d got=%b want=%b", i, {dout_valid, dout, word_done}, {1'b1, st[15-i], (i == 7 || i == 15)});
            end
            total++;
            if (s_ready !== (i >= 7)) begin
                bad++;
                $display("FAIL b2b_ready%0d got=%b want=%b", i, s_ready, (i >= 7));
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy_end got=%b want=0", busy);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task test_lsb_first;
        logic [7:0] exp_bits;
        exp_bits = 8'b10110000;
        s_data2 = 8'h0D; s_valid2 = 1'b1; en = 1'b1;
        @(negedge clk);
        s_valid2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if ({dout_valid2, dout2, word_done2} !== {1'b1, exp_bits[7-i], (i == 7)}) begin
                bad++;
                $display("FAIL lsb_bit%0d got=%b want=%b", i, {dout_valid2, dout2, word_done2}, {1'b1, exp_bits[7-i], (i == 7)});
            end
        end
        total++;
        if (busy2 !== 1'b0) begin
            bad++;
            $display("FAIL lsb_busy_end got=%b want=0", busy2);
        end
        @(negedge clk);
        en = 1'b0;
    endtask

    task test_en_toggle;
        int nb;
        int nd;
        logic e;
        nb = 0; nd = 0;
        s_data = 8'hFF; s_valid = 1'b1; en = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            e  = (k % 2 == 0);
            en = e;
            @(negedge clk);
            if (dout_valid === 1'b1) nb++;
            if (word_done === 1'b1) nd++;
            total++;
            if ({dout_valid, dout} !== {e, e}) begin
                bad++;
                $display("FAIL entog_cyc%0d got=%b want=%b", k, {dout_valid, dout}, {e, e});
            end
        end
        total++;
        if (nb != 8) begin
            bad++;
            $display("FAIL entog_bits got=%0d want=8", nb);
        end
        total++;
        if (nd != 1) begin
            bad++;
            $display("FAIL entog_done got=%0d want=1", nd);
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    task test_reset_midword;
        int nb;
        nb = 0;
        s_data = 8'hB0; s_valid = 1'b1; en = 1'b1;
        @(negedge clk);
        s_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) s_valid = 1'b0;
        end
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_held got=%b want=0", s_ready);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({dout, dout_valid, word_done, s_ready, busy} !== 5'b00010) begin
            bad++;
            $display("FAIL rstmid_async got=%b want=00010", {dout, dout_valid, word_done, s_ready, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dout_valid !== 1'b0 || busy !== 1'b0) nb++;
        end
        total++;
        if (nb != 0) begin
            bad++;
            $display("FAIL rstmid_after got=%0d active cycles want=0", nb);
        end
        en = 1'b0;
    endtask

    task test_hold_stall;
        int nb;
        int nd;
        int acc;
        logic pend;
        logic [23:0] cap;
        nb = 0; nd = 0; acc = 0; cap = '0;
        s_data = 8'hA1; s_valid = 1'b1; en = 1'b0;
        @(negedge clk);
        s_data = 8'hB2;
        @(negedge clk);
        s_data = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (s_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_ready%0d got=%b want=0", i, s_ready);
            end
        end
        en   = 1'b1;
        pend = s_valid && s_ready;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pend) begin
                s_valid = 1'b0;
                acc++;
            end
            if (dout_valid === 1'b1) begin
                cap = {cap[22:0], dout};
                nb++;
            end
            if (word_done === 1'b1) nd++;
            pend = s_valid && s_ready;
        end
        total++;
        if (acc != 1) begin
            bad++;
            $display("FAIL stall_accepts got=%0d want=1", acc);
        end
        total++;
        if (nb != 24) begin
            bad++;
            $display("FAIL stall_bits got=%0d want=24", nb);
        end
        total++;
        if (cap !== 24'hA1B2C3) begin
            bad++;
            $display("FAIL stall_stream got=%h want=a1b2c3", cap);
        end
        total++;
        if (nd != 3) begin
            bad++;
            $display("FAIL stall_done got=%0d want=3", nd);
        end
        en = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_en_toggle();
        test_reset_midword();
        test_hold_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_word_serializer

// File: doc/word_serializer.md
Name: word_serializer

Overview:
Parallel-to-serial front end that converts W-bit words into a one-bit-per-strobe stream on dout/dout_valid. It feeds the bit-serial Moore pattern detectors in the Day-series datapath. Upstream handshake is valid/ready. A one-word holding register lets back-to-back words stream with no idle bit between them.

Parameters:
- W, 8, word width in bits; W >= 2.
- MSB_FIRST, 1, 1 = bit W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0, value driven on dout whenever no bit is being emitted.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- s_data  input  W  parallel word from upstream.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  block can accept a word this cycle.
- en  input  1  bit strobe; one bit is emitted per clk edge where en=1 while shifting.
- dout  output  1  serial bit (registered).
- dout_valid  output  1  dout carries a fresh bit this cycle (registered, 1-cycle pulse per bit).
- word_done  output  1  1-cycle pulse, coincident with dout_valid of the last bit of a word.
- busy  output  1  state == SHIFT.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: state=IDLE, shreg=0, hold_full=0, bitcnt=0, dout=IDLE_LEVEL, dout_valid=0, word_done=0. s_ready is therefore 1.
- Reset mid-word: the in-flight word and the held word are discarded. No partial word completes after reset release.
- Transfer occurs on any edge with s_valid && s_ready.
- s_ready = !hold_full. It is purely a function of registered state, with no combinational path from s_valid.
- FSM states: IDLE and SHIFT; 1-bit encoding.
- IDLE, transfer at edge t:
  - shreg <= s_data, bitcnt <= 0, state -> SHIFT at t.
  - The first bit appears on dout at the first edge > t with en=1.
- IDLE, no transfer: dout = IDLE_LEVEL, dout_valid = 0.
- SHIFT, edge with en=1:
  - dout <= current bit (shreg MSB if MSB_FIRST, else LSB), dout_valid <= 1.
  - shreg shifts toward the output bit; bitcnt increments.
- SHIFT, edge with en=0:
  - dout_valid <= 0, dout <= IDLE_LEVEL.
  - shreg and bitcnt hold.
- Last bit (bitcnt == W-1 with en=1):
  - word_done <= 1.
  - If hold_full: shreg <= hold, hold_full <= 0, bitcnt <= 0, state stays SHIFT, so the next word's first bit follows on the next en edge with no gap.
  - Else: state -> IDLE.
- Transfer in SHIFT:
  - s_data is written into hold and hold_full <= 1.
  - This is legal on the same edge as a non-final bit or as the last bit. If it is the last bit and hold was empty, the incoming word loads directly into shreg instead and the state stays SHIFT.
- Hold full: s_ready=0. Upstream must hold s_data/s_valid stable until accepted.
- Width and arithmetic rules:
  - bitcnt is $clog2(W) bits.
  - bitcnt never exceeds W-1; there is no wrap past the terminal count.
- en is ignored in IDLE. A strobe held high continuously gives one bit per clk.
- Throughput with en tied 1: W bits per W cycles sustained with no bubble while hold is refilled.

Decomposition:
- Shared package serial_pkg holds:
  - the state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the default width constant SER_W=8.
- The package is reused by the downstream detectors' benches.
- One natural sub-module: ser_hold_reg. It is the single-entry holding register with full flag, load/drain controls and s_ready generation.
- The FSM, shift register and counter stay in word_serializer.

Test Plan:
- Reset, then s_data=8'hB0 with s_valid=1, en=1 constant -> dout over 8 cycles = 1,0,1,1,0,0,0,0. word_done pulses with the 8th bit, then dout=IDLE_LEVEL and busy=0.
- Words 8'hB0 then 8'h5A offered back-to-back, en=1 -> 16 consecutive dout_valid cycles. The second word's first bit (0) immediately follows the first word's last bit. s_ready=0 while hold is full.
- MSB_FIRST=0, s_data=8'h0D, en=1 -> dout = 1,0,1,1,0,0,0,0.
- en toggling 1,0,1,0 during 8'hFF -> dout_valid only on en edges. Exactly 8 valid bits are emitted over 16 cycles, and word_done pulses once.
- Assert reset after the 3rd bit of 8'hB0 with a second word held -> immediately dout=IDLE_LEVEL, dout_valid=0, s_ready=1. After release, no bits are emitted until a new transfer.
- s_valid held 1 while hold is full for 5 cycles -> no transfer occurs and s_data is sampled exactly once, on the edge where s_ready returns to 1.
